// File: rtl/pipe_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_demux_pkg
// Description : Shared constants, types and helpers for pipe_indication_demux.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_demux_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = '1;

    // Range check done in 33 bits so base + n can never wrap.
    function automatic logic tag_in_range(input logic [31:0] tag,
                                          input logic [31:0] base,
                                          input logic [31:0] n);
        logic [32:0] lim;
        lim = {1'b0, base} + {1'b0, n};
        return ({1'b0, tag} >= {1'b0, base}) && ({1'b0, tag} < lim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_chan_fifo.sv
`default_nettype none
// ============================================================================
// Module      : demux_chan_fifo
// Description : Per-channel indication FIFO with optional empty cut-through.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_chan_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_rdy_i,
    output logic              full_o,
    output logic              empty_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              cut;
    logic              store;
    logic              pop;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // Cut-through: an empty FIFO presents the incoming message directly.
    assign cut     = (BYPASS != 0) && empty_o && push_i;
    assign valid_o = !empty_o || cut;
    assign data_o  = cut ? push_data_i : mem_q[rd_ptr_q[AW-1:0]];

    // A cut-through message consumed in the same cycle is never stored.
    assign pop     = !empty_o && pop_rdy_i;
    assign store   = push_i && !(cut && pop_rdy_i);

    // Pointer next-state: each pointer advances on its own event.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, store};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Pointer and storage registers; reset empties the FIFO and zeroes data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (store) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_indication_demux.sv
`default_nettype none
// ============================================================================
// Module      : pipe_indication_demux
// Description : Routes tagged pipe messages to per-channel indication FIFOs;
//               out-of-range tags are dropped, counted and reported.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_indication_demux
    import pipe_demux_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 1,
    parameter int DEPTH    = 2,
    parameter int BYPASS   = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     enq_ena,
    output logic                     enq_rdy,
    input  logic [TAG_W-1:0]         enq_tag,
    input  logic [DATA_W-1:0]        enq_data,
    output logic [NUM_CH-1:0]        ind_valid,
    input  logic [NUM_CH-1:0]        ind_rdy,
    output logic [NUM_CH*DATA_W-1:0] ind_data,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     bad_tag_valid,
    output logic [TAG_W-1:0]         bad_tag,
    input  logic                     bad_clr
);

    logic [31:0]       tag_ext;
    logic              hit;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] pass;
    logic [NUM_CH-1:0] push;
    logic              drop;

    cnt_t              drop_cnt_q, drop_cnt_d;
    logic              bad_valid_q, bad_valid_d;
    logic [TAG_W-1:0]  bad_tag_q, bad_tag_d;

    assign tag_ext = {{(32-TAG_W){1'b0}}, enq_tag};
    assign hit     = tag_in_range(tag_ext, 32'(TAG_BASE), 32'(NUM_CH));

    // In cut-through mode a full channel still accepts when its consumer pops.
    assign pass    = (BYPASS != 0) ? ind_rdy : '0;
    assign enq_rdy = !(|(sel & full & ~pass));
    assign drop    = enq_ena && !hit;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            assign sel[i]  = hit && (tag_ext == 32'(TAG_BASE + i));
            assign push[i] = enq_ena && enq_rdy && sel[i];

            demux_chan_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH),
                .BYPASS (BYPASS)
            ) u_fifo (
                .clk_i       (CLK),
                .rst_i       (RST),
                .push_i      (push[i]),
                .push_data_i (enq_data),
                .pop_rdy_i   (ind_rdy[i]),
                .full_o      (full[i]),
                .empty_o     (empty[i]),
                .valid_o     (ind_valid[i]),
                .data_o      (ind_data[i*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Drop bookkeeping: clear wins over a same-cycle drop; count saturates.
    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        bad_valid_d = bad_valid_q;
        bad_tag_d   = bad_tag_q;
        if (bad_clr) begin
            drop_cnt_d  = '0;
            bad_valid_d = 1'b0;
            bad_tag_d   = '0;
        end else if (drop) begin
            if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + cnt_t'(1);
            end
            bad_valid_d = 1'b1;
            bad_tag_d   = enq_tag;
        end
    end

    // Drop/error state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_cnt_q  <= '0;
            bad_valid_q <= 1'b0;
            bad_tag_q   <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            bad_valid_q <= bad_valid_d;
            bad_tag_q   <= bad_tag_d;
        end
    end

    assign drop_count    = drop_cnt_q;
    assign bad_tag_valid = bad_valid_q;
    assign bad_tag       = bad_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_indication_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_indication_demux
// Description : Self-checking bench; registered and cut-through instances
//               share stimulus and are compared against an occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_indication_demux;

    localparam int NCH   = 4;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int TBASE = 1;
    localparam int DEP   = 2;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            enq_ena = 1'b0;
    logic [TW-1:0]   enq_tag = '0;
    logic [DW-1:0]   enq_data = '0;
    logic [NCH-1:0]  ind_rdy = '0;
    logic            bad_clr = 1'b0;

    logic            rdy0, rdy1;
    logic [NCH-1:0]  val0, val1;
    logic [NCH*DW-1:0] dat0, dat1;
    logic [15:0]     dc0, dc1;
    logic            bv0, bv1;
    logic [TW-1:0]   bt0, bt1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    pipe_indication_demux #(.NUM_CH(NCH), .DATA_W(DW), .TAG_W(TW), .TAG_BASE(TBASE),
                            .DEPTH(DEP), .BYPASS(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .enq_ena(enq_ena), .enq_rdy(rdy0), .enq_tag(enq_tag),
        .enq_data(enq_data), .ind_valid(val0), .ind_rdy(ind_rdy), .ind_data(dat0),
        .drop_count(dc0), .bad_tag_valid(bv0), .bad_tag(bt0), .bad_clr(bad_clr));

    pipe_indication_demux #(.NUM_CH(NCH), .DATA_W(DW), .TAG_W(TW), .TAG_BASE(TBASE),
                            .DEPTH(DEP), .BYPASS(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .enq_ena(enq_ena), .enq_rdy(rdy1), .enq_tag(enq_tag),
        .enq_data(enq_data), .ind_valid(val1), .ind_rdy(ind_rdy), .ind_data(dat1),
        .drop_count(dc1), .bad_tag_valid(bv1), .bad_tag(bt1), .bad_clr(bad_clr));

    // Reference model: per-channel message lists with occupancy counts.
    logic [DW-1:0] mdata [2][NCH][DEP];
    int            mcnt  [2][NCH];
    int            mdrop [2];
    logic          mbv   [2];
    logic [TW-1:0] mbt   [2];
    logic          e_rdy   [2];
    logic [NCH-1:0] e_valid [2];
    logic [DW-1:0] e_data  [2][NCH];
    logic          e_empty [2][NCH];

    typedef struct {
        logic          ena;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic [NCH-1:0] rdy;
        logic          clr;
        logic          x_rdy;
        logic [NCH-1:0] x_valid;
        logic [15:0]   x_drop;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NCH; i++) mcnt[b][i] = 0;
            mdrop[b] = 0;
            mbv[b]   = 1'b0;
            mbt[b]   = '0;
        end
    endtask

    function automatic logic tag_hit();
        return (int'(enq_tag) >= TBASE) && (int'(enq_tag) < TBASE + NCH);
    endfunction

    task automatic model_eval(input int b);
        logic hit;
        int   ch;
        hit = tag_hit();
        ch  = int'(enq_tag) - TBASE;
        for (int i = 0; i < NCH; i++) begin
            e_empty[b][i] = (mcnt[b][i] == 0);
            if (mcnt[b][i] > 0) begin
                e_valid[b][i] = 1'b1;
                e_data[b][i]  = mdata[b][i][0];
            end else if (b == 1 && enq_ena && hit && ch == i) begin
                e_valid[b][i] = 1'b1;
                e_data[b][i]  = enq_data;
            end else begin
                e_valid[b][i] = 1'b0;
                e_data[b][i]  = '0;
            end
        end
        if (!hit) e_rdy[b] = 1'b1;
        else      e_rdy[b] = (mcnt[b][ch] < DEP) || (b == 1 && ind_rdy[ch]);
    endtask

    task automatic model_commit(input int b);
        logic hit;
        logic acc;
        int   ch;
        hit = tag_hit();
        ch  = int'(enq_tag) - TBASE;
        acc = enq_ena && e_rdy[b];
        for (int i = 0; i < NCH; i++) begin
            if (e_valid[b][i] && ind_rdy[i] && !e_empty[b][i]) begin
                for (int k = 0; k < DEP - 1; k++) mdata[b][i][k] = mdata[b][i][k+1];
                mcnt[b][i]--;
            end
        end
        if (acc && hit && !(b == 1 && e_empty[b][ch] && ind_rdy[ch])) begin
            mdata[b][ch][mcnt[b][ch]] = enq_data;
            mcnt[b][ch]++;
        end
        if (bad_clr) begin
            mdrop[b] = 0;
            mbv[b]   = 1'b0;
            mbt[b]   = '0;
        end else if (acc && !hit) begin
            if (mdrop[b] < 16'hFFFF) mdrop[b]++;
            mbv[b] = 1'b1;
            mbt[b] = enq_tag;
        end
    endtask

    task automatic compare(input int b);
        logic          a_rdy, a_bv;
        logic [NCH-1:0] a_val;
        logic [NCH*DW-1:0] a_dat;
        logic [15:0]   a_dc;
        logic [TW-1:0] a_bt;
        a_rdy = b ? rdy1 : rdy0;
        a_val = b ? val1 : val0;
        a_dat = b ? dat1 : dat0;
        a_dc  = b ? dc1  : dc0;
        a_bv  = b ? bv1  : bv0;
        a_bt  = b ? bt1  : bt0;
        chk($sformatf("dut%0d.enq_rdy", b), 32'(a_rdy), 32'(e_rdy[b]));
        chk($sformatf("dut%0d.ind_valid", b), 32'(a_val), 32'(e_valid[b]));
        for (int i = 0; i < NCH; i++)
            if (e_valid[b][i])
                chk($sformatf("dut%0d.ind_data[%0d]", b, i), a_dat[i*DW +: DW], e_data[b][i]);
        chk($sformatf("dut%0d.drop_count", b), 32'(a_dc), 32'(mdrop[b]));
        chk($sformatf("dut%0d.bad_tag_valid", b), 32'(a_bv), 32'(mbv[b]));
        chk($sformatf("dut%0d.bad_tag", b), 32'(a_bt), 32'(mbt[b]));
    endtask

    task automatic setin(input logic ena, input logic [TW-1:0] tag, input logic [DW-1:0] data,
                         input logic [NCH-1:0] rdy, input logic clr);
        enq_ena  = ena;
        enq_tag  = tag;
        enq_data = data;
        ind_rdy  = rdy;
        bad_clr  = clr;
    endtask

    task automatic phase_check(input bit do_chk);
        #1;
        model_eval(0);
        model_eval(1);
        if (do_chk) begin
            compare(0);
            compare(1);
        end
    endtask

    task automatic phase_commit();
        @(posedge CLK);
        model_commit(0);
        model_commit(1);
        @(negedge CLK);
    endtask

    task automatic step(input bit do_chk);
        phase_check(do_chk);
        phase_commit();
    endtask

    initial begin
        //             ena tag  data          rdy      clr x_rdy x_valid  x_drop
        tbl[0]  = '{1'b1, 4'd1, 32'hA5A5_0001, 4'b1111, 1'b0, 1'b1, 4'b0000, 16'd0};
        tbl[1]  = '{1'b0, 4'd0, 32'h0,         4'b1111, 1'b0, 1'b1, 4'b0001, 16'd0};
        tbl[2]  = '{1'b0, 4'd0, 32'h0,         4'b1111, 1'b0, 1'b1, 4'b0000, 16'd0};
        tbl[3]  = '{1'b1, 4'd3, 32'h10,        4'b1011, 1'b0, 1'b1, 4'b0000, 16'd0};
        tbl[4]  = '{1'b1, 4'd3, 32'h11,        4'b1011, 1'b0, 1'b1, 4'b0100, 16'd0};
        tbl[5]  = '{1'b1, 4'd3, 32'h12,        4'b1011, 1'b0, 1'b0, 4'b0100, 16'd0};
        tbl[6]  = '{1'b1, 4'd2, 32'h20,        4'b1011, 1'b0, 1'b1, 4'b0100, 16'd0};
        tbl[7]  = '{1'b1, 4'd3, 32'h12,        4'b1111, 1'b0, 1'b0, 4'b0110, 16'd0};
        tbl[8]  = '{1'b1, 4'd3, 32'h12,        4'b1111, 1'b0, 1'b1, 4'b0100, 16'd0};
        tbl[9]  = '{1'b0, 4'd0, 32'h0,         4'b1111, 1'b0, 1'b1, 4'b0100, 16'd0};
        tbl[10] = '{1'b0, 4'd0, 32'h0,         4'b1111, 1'b0, 1'b1, 4'b0000, 16'd0};
        tbl[11] = '{1'b1, 4'd0, 32'hB0,        4'b1111, 1'b0, 1'b1, 4'b0000, 16'd0};
        tbl[12] = '{1'b1, 4'd5, 32'hB5,        4'b1111, 1'b0, 1'b1, 4'b0000, 16'd1};
        tbl[13] = '{1'b1, 4'd15, 32'hBF,       4'b1111, 1'b0, 1'b1, 4'b0000, 16'd2};
        tbl[14] = '{1'b0, 4'd0, 32'h0,         4'b1111, 1'b0, 1'b1, 4'b0000, 16'd3};
        tbl[15] = '{1'b1, 4'd0, 32'hC0,        4'b1111, 1'b1, 1'b1, 4'b0000, 16'd3};
        tbl[16] = '{1'b0, 4'd0, 32'h0,         4'b1111, 1'b0, 1'b1, 4'b0000, 16'd0};

        model_reset();
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        // Reset state.
        #1;
        chk("reset ind_valid0", 32'(val0), 32'h0);
        chk("reset ind_valid1", 32'(val1), 32'h0);
        chk("reset ind_data0 zero", 32'(|dat0), 32'h0);
        chk("reset ind_data1 zero", 32'(|dat1), 32'h0);
        chk("reset drop_count", 32'(dc0), 32'h0);
        chk("reset bad_tag_valid", 32'(bv0), 32'h0);
        chk("reset bad_tag", 32'(bt0), 32'h0);
        @(negedge CLK);

        // Directed table on the registered instance, with model on both.
        for (int r = 0; r < 17; r++) begin
            setin(tbl[r].ena, tbl[r].tag, tbl[r].data, tbl[r].rdy, tbl[r].clr);
            phase_check(1);
            chk($sformatf("tbl[%0d].enq_rdy", r), 32'(rdy0), 32'(tbl[r].x_rdy));
            chk($sformatf("tbl[%0d].ind_valid", r), 32'(val0), 32'(tbl[r].x_valid));
            chk($sformatf("tbl[%0d].drop_count", r), 32'(dc0), 32'(tbl[r].x_drop));
            if (r == 1) chk("tbl first delivery data", dat0[31:0], 32'hA5A5_0001);
            if (r == 14) chk("tbl bad_tag", 32'(bt0), 32'd15);
            if (r == 16) chk("tbl clr flag", 32'(bv0), 32'd0);
            phase_commit();
        end

        // Cut-through: empty ch1 with consumer ready delivers in the same cycle.
        setin(1'b1, 4'd2, 32'h55, 4'b0010, 1'b0);
        phase_check(1);
        chk("bypass same-cycle valid", 32'(val1[1]), 32'd1);
        chk("bypass same-cycle data", dat1[63:32], 32'h55);
        phase_commit();
        setin(1'b0, 4'd0, 32'h0, 4'b0010, 1'b0);
        phase_check(1);
        chk("bypass not stored", 32'(val1[1]), 32'd0);
        phase_commit();
        setin(1'b1, 4'd2, 32'h66, 4'b0000, 1'b0);
        step(1);
        setin(1'b0, 4'd0, 32'h0, 4'b0000, 1'b0);
        phase_check(1);
        chk("bypass stored valid", 32'(val1[1]), 32'd1);
        chk("bypass stored data", dat1[63:32], 32'h66);
        phase_commit();
        setin(1'b0, 4'd0, 32'h0, 4'b0010, 1'b0);
        step(1);
        step(1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [TW-1:0] t;
            t = ($urandom_range(0, 9) == 0) ? TW'($urandom_range(0, 15)) : TW'($urandom_range(0, 5));
            setin(($urandom_range(0, 3) != 0), t, $urandom, NCH'($urandom),
                  ($urandom_range(0, 60) == 0));
            step(1);
        end

        // Saturation of the drop counter.
        setin(1'b0, 4'd0, 32'h0, 4'b1111, 1'b1);
        step(1);
        setin(1'b1, 4'd9, 32'hDEAD, 4'b1111, 1'b0);
        for (int n = 0; n < 70000; n++) step(0);
        setin(1'b0, 4'd0, 32'h0, 4'b1111, 1'b0);
        phase_check(1);
        chk("saturated drop_count0", 32'(dc0), 32'hFFFF);
        chk("saturated drop_count1", 32'(dc1), 32'hFFFF);
        phase_commit();

        // Asynchronous reset with ch0 holding two entries.
        setin(1'b1, 4'd1, 32'hAA, 4'b0000, 1'b0);
        step(1);
        setin(1'b1, 4'd1, 32'hBB, 4'b0000, 1'b0);
        step(1);
        setin(1'b0, 4'd0, 32'h0, 4'b0000, 1'b0);
        #3;
        RST = 1'b1;
        #1;
        chk("async reset ind_valid0", 32'(val0), 32'h0);
        chk("async reset ind_valid1", 32'(val1), 32'h0);
        chk("async reset drop_count", 32'(dc0), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        setin(1'b1, 4'd1, 32'hC0DE_0001, 4'b0000, 1'b0);
        step(1);
        setin(1'b0, 4'd0, 32'h0, 4'b1111, 1'b0);
        phase_check(1);
        chk("post-reset valid0", 32'(val0), 32'h1);
        chk("post-reset data0", dat0[31:0], 32'hC0DE_0001);
        phase_commit();
        step(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_indication_demux.md
Name: pipe_indication_demux

Overview:
- Parametrised successor to the single-method pipe-to-indication input adapter.
- Accepts tagged messages from one inbound pipe. Routes each to one of NUM_CH indication channels by tag.
- Each channel has its own DEPTH-entry FIFO, so a stalled channel blocks only messages tagged for it.
- Out-of-range tags are consumed, counted and reported, never delivered. Sits between the transport pipe and the indication consumers.

Parameters:
- NUM_CH, 4, number of indication channels (1..16).
- DATA_W, 32, payload width in bits.
- TAG_W, 4, tag width in bits.
- TAG_BASE, 1, tag value of channel 0; channel i owns tag TAG_BASE+i.
- DEPTH, 2, per-channel FIFO entries (power of 2, >=2).
- BYPASS, 0, 1 = empty-FIFO cut-through (zero latency), 0 = registered (1-cycle latency).

Ports:
- CLK, in, 1, clock.
- RST, in, 1, reset, asynchronous, active-high.
- enq_ena, in, 1, pipe enqueue enable; message commits when enq_ena && enq_rdy.
- enq_rdy, out, 1, pipe ready.
- enq_tag, in, TAG_W, message tag.
- enq_data, in, DATA_W, message payload.
- ind_valid, out, NUM_CH, per-channel message available.
- ind_rdy, in, NUM_CH, per-channel consumer ready; pop when ind_valid[i] && ind_rdy[i].
- ind_data, out, NUM_CH*DATA_W, per-channel payload; channel i occupies bits [i*DATA_W +: DATA_W].
- drop_count, out, 16, saturating count of dropped bad-tag messages.
- bad_tag_valid, out, 1, sticky flag: at least one bad tag has been seen.
- bad_tag, out, TAG_W, tag of the most recent dropped message.
- bad_clr, in, 1, clears drop_count, bad_tag_valid and bad_tag.

Behaviour:
- Reset (RST high, asynchronous): all FIFOs empty, all pointers 0, ind_valid=0, drop_count=0, bad_tag_valid=0, bad_tag=0. ind_data is don't-care while ind_valid is 0, but is driven to 0 after reset. Reset mid-transfer discards all buffered messages.
- Decode: hit = (enq_tag >= TAG_BASE) && (enq_tag < TAG_BASE+NUM_CH). Compare widths are extended so TAG_BASE+NUM_CH cannot overflow. ch = enq_tag - TAG_BASE.
- enq_rdy, BYPASS=0: 1 if !hit; otherwise !full[ch].
  - Push-when-full with a same-cycle pop is not accepted.
  - enq_rdy never depends on ind_rdy.
- enq_rdy, BYPASS=1: additionally 1 when hit, full[ch] and ind_rdy[ch] are all true.
- Accept, hit, BYPASS=0: write entry at wr_ptr[ch]. ind_valid[ch] rises the next cycle (latency 1). Message order within a channel is preserved.
- Accept, hit, BYPASS=1, FIFO[ch] empty and ind_rdy[ch]=1: message appears on ind_valid/ind_data[ch] in the same cycle and is not stored. Otherwise the message is stored as in BYPASS=0.
- ind_valid[i], BYPASS=1 with FIFO[i] empty: mirrors (enq_ena && hit && ch==i) combinationally.
- Pop: on ind_valid[i] && ind_rdy[i], advance rd_ptr[i]. ind_valid[i] may drop only after a pop.
- Simultaneous push and pop on a non-empty channel: occupancy unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Full/empty use an extra wrap bit per pointer.
- Accept, !hit: message is discarded.
  - drop_count increments, saturating at 0xFFFF.
  - bad_tag <= enq_tag; bad_tag_valid <= 1.
- bad_clr has priority over a same-cycle drop: result is count 0, flag 0.
- Cross-channel independence: a full channel stalls the pipe only while the head message targets it. No reordering across the pipe is permitted, so head-of-line blocking is intended.

Decomposition:
- Package pipe_demux_pkg:
  - function tag_in_range(tag, base, n).
  - localparam CNT_W=16.
  - typedef for the saturating counter.
- Sub-module demux_chan_fifo, instantiated NUM_CH times:
  - Parameters DATA_W, DEPTH, BYPASS.
  - Push/pop ports, full/empty, head data, bypass path.
- Top level holds tag decode, enq_rdy mux and drop/error logic.

Test Plan:
- Reset release, then tag=1, data=0xA5A5_0001, enq_ena 1 cycle, ind_rdy=0xF -> ind_valid=0001 one cycle later, ind_data[31:0]=0xA5A5_0001, popped the same cycle; drop_count=0.
- ind_rdy[2]=0, push tag=3 three times (0x10, 0x11, 0x12) -> first two accepted, enq_rdy=0 on the third. Meanwhile push tag=2 with 0x20: blocked only while the head targets ch2. Raise ind_rdy[2] -> 0x10, 0x11, 0x12 delivered in order.
- Push tags 0, 5 and 15 -> all accepted with enq_rdy=1, nothing delivered, drop_count=3, bad_tag=15, bad_tag_valid=1. bad_clr together with a drop of tag 0 -> drop_count=0, flag=0.
- BYPASS=1, empty ch1, ind_rdy[1]=1, push tag=2 data 0x55 -> ind_valid[1]=1 in the same cycle with 0x55, occupancy stays 0. With ind_rdy[1]=0 -> stored, delivered 1 cycle after ind_rdy rises.
- 70000 bad-tag pushes -> drop_count stops at 0xFFFF.
- Assert RST while ch0 holds 2 entries -> ind_valid=0 immediately (async). After release, a new tag=1 message is delivered with no stale data.
